// File: rtl/upsample_2x2.sv
// Streaming 2x2 nearest-neighbour upsampler. Each input pixel is emitted twice
// on the even output row, and the row is replayed from a line buffer for the odd row.
module upsample_2x2 #(
  parameter int DATA_WIDTH   = 20,
  parameter int INPUT_WIDTH  = 13,
  parameter int INPUT_HEIGHT = 13
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         frame_done
);

  localparam int COL_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam int ROW_W = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(INPUT_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(INPUT_HEIGHT - 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t                                  state, state_n;
  logic [COL_W-1:0]                        col, col_n;
  logic [ROW_W-1:0]                        row, row_n;
  logic                                    dup, dup_n;
  logic signed [DATA_WIDTH-1:0]            hold, hold_n;
  logic signed [DATA_WIDTH-1:0]            data_n;
  logic                                    valid_n;
  logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0]  row_buf;
  logic                                    arm;
  logic                                    last_pend;
  logic                                    slot, adv, in_acc, fire;

  assign slot      = !valid_out || ready_in;
  assign adv       = enable && slot;
  assign ready_out = enable && (state == FILL) && !dup && slot;
  assign in_acc    = valid_in && ready_out;
  // A beat only transfers when the block is enabled; otherwise it stays presented.
  assign fire      = enable && valid_out && ready_in;

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    dup_n   = dup;
    hold_n  = hold;
    data_n  = data_out;
    valid_n = valid_out;
    arm     = 1'b0;
    if (adv) begin
      unique case (state)
        FILL: begin
          if (!dup) begin
            if (valid_in) begin
              hold_n  = data_in;
              data_n  = data_in;
              valid_n = 1'b1;
              dup_n   = 1'b1;
            end else begin
              valid_n = 1'b0;
            end
          end else begin
            data_n  = hold;
            valid_n = 1'b1;
            dup_n   = 1'b0;
            if (col == COL_LAST) begin
              col_n   = '0;
              state_n = REPLAY;
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
        REPLAY: begin
          data_n  = row_buf[col];
          valid_n = 1'b1;
          dup_n   = !dup;
          if (dup) begin
            if (col == COL_LAST) begin
              col_n   = '0;
              state_n = FILL;
              if (row == ROW_LAST) begin
                row_n = '0;
                arm   = 1'b1;
              end else begin
                row_n = row + 1'b1;
              end
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
        default: state_n = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      col       <= '0;
      row       <= '0;
      dup       <= 1'b0;
      hold      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      dup       <= dup_n;
      hold      <= hold_n;
      data_out  <= data_n;
      valid_out <= valid_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row_buf <= '0;
    else if (in_acc) row_buf[col] <= data_in;
  end

  // last_pend marks that the beat now loaded is the frame's final one; the pulse
  // follows its transfer, which may be delayed by backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fire && last_pend;
      if (arm)       last_pend <= 1'b1;
      else if (fire) last_pend <= 1'b0;
    end
  end

endmodule
